// File: rtl/edge_log_pkg.sv
// Shared record layout and FSM encoding for the edge event logger.
// Records always carry a 32-bit dtime slot; the logger uses its low TS_W bits (TS_W <= 32).
package edge_log_pkg;

   localparam int REC_DTIME_W = 32;

   typedef struct packed {
      logic                   lost;
      logic                   kind;
      logic                   level;
      logic [REC_DTIME_W-1:0] dtime;
   } rec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } log_state_e;

   localparam logic KIND_EDGE = 1'b0;
   localparam logic KIND_KEEP = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write while full is accepted when a read happens
// in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             rd_ok;
   logic             wr_ok;

   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign empty_o   = (level_o == '0);
   assign full_o    = (level_o == (AW+1)'(DEPTH));
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   assign rd_ok = rd_en_i && !empty_o;
   assign wr_ok = wr_en_i && (!full_o || rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage holds no control state, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/edge_event_logger.sv
// Captures a filtered digital input as {dtime, level} records queued behind a valid/ready port.
// dtime counts cycles since the previous generated record, including records that were dropped.
module edge_event_logger
   import edge_log_pkg::*;
#(
   parameter int TS_W        = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int GLITCH_CYC  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          din,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [TS_W-1:0]               rec_dtime,
   output logic                          rec_level,
   output logic                          rec_kind,
   output logic                          rec_lost,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int               STAB_W = $clog2(GLITCH_CYC + 1);
   localparam logic [TS_W-1:0]  DT_MAX = '1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ds;
   logic                   flt_q, flt_d;
   logic [STAB_W-1:0]      stab_q, stab_d;
   logic                   commit_d, commit_q;
   log_state_e             state_q, state_d;
   logic [TS_W-1:0]        dcnt_q, dcnt_d;
   logic                   lost_q, lost_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;

   logic                   push;
   logic                   push_kind;
   logic [TS_W-1:0]        push_dt;
   logic                   pop;
   logic                   accept;
   logic                   drop;
   logic                   fifo_full;
   logic                   fifo_empty;
   rec_t                   wr_rec;
   rec_t                   head;

   assign ds = sync_q[SYNC_STAGES-1];

   // Glitch filter: a new level must disagree with flt for GLITCH_CYC consecutive cycles.
   always_comb begin
      flt_d    = flt_q;
      stab_d   = '0;
      commit_d = 1'b0;
      if (en && (ds != flt_q)) begin
         if (stab_q == STAB_W'(GLITCH_CYC - 1)) begin
            commit_d = 1'b1;
            flt_d    = ds;
         end else begin
            stab_d = stab_q + STAB_W'(1);
         end
      end
   end

   // Recording FSM; the commit is seen one cycle late, after flt already holds the new level.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      push      = 1'b0;
      push_kind = KIND_EDGE;
      push_dt   = '0;
      if (!en) begin
         state_d = IDLE;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: state_d = START;
            START: begin
               push    = 1'b1;
               dcnt_d  = TS_W'(1);
               state_d = RUN;
            end
            RUN: begin
               if (commit_q) begin
                  push    = 1'b1;
                  push_dt = dcnt_q;
                  dcnt_d  = TS_W'(1);
               end else if (dcnt_q == DT_MAX) begin
                  push      = 1'b1;
                  push_kind = KIND_KEEP;
                  push_dt   = DT_MAX;
                  dcnt_d    = TS_W'(1);
               end else begin
                  dcnt_d = dcnt_q + TS_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign pop    = !fifo_empty && rec_ready;
   assign accept = push && (!fifo_full || pop);
   assign drop   = push && fifo_full && !pop;

   always_comb begin
      lost_d     = lost_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         lost_d     = 1'b1;
         drop_cnt_d = sat_inc16(drop_cnt_q);
      end else if (accept) begin
         lost_d = 1'b0;
      end
   end

   always_comb begin
      wr_rec.lost  = lost_q;
      wr_rec.kind  = push_kind;
      wr_rec.level = flt_q;
      wr_rec.dtime = REC_DTIME_W'(push_dt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         flt_q      <= 1'b0;
         stab_q     <= '0;
         commit_q   <= 1'b0;
         state_q    <= IDLE;
         dcnt_q     <= '0;
         lost_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
         flt_q      <= flt_d;
         stab_q     <= stab_d;
         commit_q   <= commit_d;
         state_q    <= state_d;
         dcnt_q     <= dcnt_d;
         lost_q     <= lost_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(rec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept),
      .wr_data_i (wr_rec),
      .rd_en_i   (rec_ready),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   // Head fields are masked while empty so unwritten storage never reaches the sink.
   assign rec_valid = !fifo_empty;
   assign rec_dtime = rec_valid ? head.dtime[TS_W-1:0] : '0;
   assign rec_level = rec_valid && head.level;
   assign rec_kind  = rec_valid && head.kind;
   assign rec_lost  = rec_valid && head.lost;
   assign drop_cnt  = drop_cnt_q;

endmodule
